fwd_hazard_ctrl: RTL and testbench

Parametrised forwarding and hazard controller for the in-order pipeline. It keeps a shadow of the in-flight destination registers for the stages after ID (ID/EX = stage 0, EX/MEM = stage 1, MEM/WB = stage 2, and so on). It decodes the youngest-producer forwarding selects for the EX operands and the MEM store-data forward. It also generates the ID stall for loads whose data is not yet available, with configurable depth, source count and load latency.

---
 rtl/fwd_pkg.sv | 34 +++
 rtl/fwd_match_enc.sv | 48 ++++
 rtl/fwd_hazard_ctrl.sv | 141 ++++++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fwd_pkg : shared entry type and helpers for the forwarding/hazard controller
// Revision: 1.0
// ---------------------------------------------------------------------------
package fwd_pkg;

  // Register fields are held at a fixed maximum width so the entry type can
  // live in a package; narrower register addresses are zero-extended.
  localparam int FWD_RW_MAX  = 8;
  localparam int FWD_MAX_ENT = 16;
  localparam int FWD_RF      = 0;

  typedef struct packed {
    logic                  valid;
    logic [FWD_RW_MAX-1:0] rd;
    logic                  wr;
    logic                  load;
    logic                  store;
    logic [FWD_RW_MAX-1:0] st_rs;
  } fwd_entry_t;

  // Lowest set index wins (youngest producer); -1 when nothing matches.
  function automatic int fwd_youngest(input logic [FWD_MAX_ENT-1:0] hits);
    int idx;
    idx = -1;
    for (int i = FWD_MAX_ENT - 1; i >= 0; i--) begin
      if (hits[i]) idx = i;
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_match_enc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fwd_match_enc : youngest in-flight producer lookup for one source register
// Revision: 1.0
// ---------------------------------------------------------------------------
module fwd_match_enc
  import fwd_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int SELW  = $clog2(DEPTH + 1)
) (
  input  fwd_entry_t [DEPTH:0]  ents,
  input  logic [FWD_RW_MAX-1:0] rs,
  input  logic                  used,
  output logic                  hit,
  output logic [SELW-1:0]       stage,
  output logic                  is_load
);

  logic [FWD_MAX_ENT-1:0] w_hits;
  int                     w_idx;
  logic                   w_unused_fields;

  always_comb begin
    w_hits          = '0;
    w_unused_fields = 1'b0;
    for (int j = 0; j <= DEPTH; j++) begin
      w_hits[j] = used & ents[j].valid & ents[j].wr & (ents[j].rd == rs);
      w_unused_fields = w_unused_fields ^ ents[j].store ^ (^ents[j].st_rs);
    end
  end

  // stage is the entry index j of the youngest match
  always_comb begin
    w_idx   = fwd_youngest(w_hits);
    hit     = (w_idx >= 0);
    stage   = '0;
    is_load = 1'b0;
    for (int j = 0; j <= DEPTH; j++) begin
      if (w_idx == j) begin
        stage   = SELW'(j);
        is_load = ents[j].load;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fwd_hazard_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fwd_hazard_ctrl : EX/store-data forward selects and load-use ID stall
// Revision: 1.0
// ---------------------------------------------------------------------------
module fwd_hazard_ctrl
  import fwd_pkg::*;
#(
  parameter int NUM_SRC    = 2,
  parameter int RW         = 5,
  parameter int DEPTH      = 2,
  parameter int LOAD_STAGE = 2,
  parameter int STORE_SRC  = 1,
  parameter int SELW       = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    id_valid_i,
  input  logic [NUM_SRC*RW-1:0]   id_rs_i,
  input  logic [NUM_SRC-1:0]      id_rs_used_i,
  input  logic [RW-1:0]           id_rd_i,
  input  logic                    id_regwrite_i,
  input  logic                    id_load_i,
  input  logic                    id_store_i,
  input  logic                    hold_i,
  input  logic                    flush_i,
  output logic                    stall_o,
  output logic [NUM_SRC*SELW-1:0] ex_fwd_sel_o,
  output logic                    mem_st_fwd_o,
  output logic [SELW-1:0]         mem_st_fwd_sel_o
);

  fwd_entry_t [DEPTH:0]    r_ent;
  fwd_entry_t [DEPTH:0]    w_st_ents;
  fwd_entry_t              w_new;
  logic [NUM_SRC-1:0]      w_hit;
  logic [NUM_SRC-1:0]      w_load;
  logic [NUM_SRC*SELW-1:0] w_stage;
  logic                    w_st_hit;
  logic                    w_st_load;
  logic [SELW-1:0]         w_st_stage;
  logic                    w_st_ok;
  logic                    w_stall;
  logic                    w_take;
  logic [NUM_SRC*SELW-1:0] r_ex_sel;
  logic                    r_st_fwd;
  logic [SELW-1:0]         r_st_sel;

  always_comb begin
    w_new       = '0;
    w_new.valid = 1'b1;
    w_new.rd    = FWD_RW_MAX'(id_rd_i);
    w_new.wr    = id_regwrite_i & (id_rd_i != '0);
    w_new.load  = id_load_i;
    w_new.store = id_store_i;
    w_new.st_rs = FWD_RW_MAX'(id_rs_i[STORE_SRC*RW +: RW]);
  end

  generate
    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
      fwd_match_enc #(
        .DEPTH (DEPTH),
        .SELW  (SELW)
      ) u_enc (
        .ents    (r_ent),
        .rs      (FWD_RW_MAX'(id_rs_i[s*RW +: RW])),
        .used    (id_rs_used_i[s]),
        .hit     (w_hit[s]),
        .stage   (w_stage[s*SELW +: SELW]),
        .is_load (w_load[s])
      );
    end
  endgenerate

  // The store in e[0] must not match itself, so its own slot is masked out.
  always_comb begin
    w_st_ents          = r_ent;
    w_st_ents[0].valid = 1'b0;
  end

  fwd_match_enc #(
    .DEPTH (DEPTH),
    .SELW  (SELW)
  ) u_st_enc (
    .ents    (w_st_ents),
    .rs      (r_ent[0].st_rs),
    .used    (r_ent[0].valid & r_ent[0].store),
    .hit     (w_st_hit),
    .stage   (w_st_stage),
    .is_load (w_st_load)
  );

  // Store data is consumed one stage later, so that source may tolerate a
  // load that is one stage younger.
  always_comb begin
    w_stall = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (w_hit[s] && w_load[s]) begin
        if ((s == STORE_SRC) && id_store_i) begin
          if (int'(w_stage[s*SELW +: SELW]) + 2 < LOAD_STAGE) w_stall = 1'b1;
        end else if (int'(w_stage[s*SELW +: SELW]) + 1 < LOAD_STAGE) begin
          w_stall = 1'b1;
        end
      end
    end
  end

  assign stall_o = ~rst & id_valid_i & ~flush_i & w_stall;
  assign w_take  = id_valid_i & ~stall_o & ~flush_i;
  assign w_st_ok = r_ent[0].valid & r_ent[0].store & ~flush_i & w_st_hit &
                   w_st_load & (int'(w_st_stage) < DEPTH);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ent    <= '0;
      r_ex_sel <= '0;
      r_st_fwd <= 1'b0;
      r_st_sel <= '0;
    end else if (!hold_i) begin
      r_ent[0] <= w_take ? w_new : '0;
      for (int k = 1; k <= DEPTH; k++) begin
        r_ent[k] <= r_ent[k-1];
      end
      if (flush_i) r_ent[1] <= '0;
      // A producer in e[DEPTH] retires this edge, so the register file has it.
      for (int s = 0; s < NUM_SRC; s++) begin
        r_ex_sel[s*SELW +: SELW] <=
          (w_take && w_hit[s] && (int'(w_stage[s*SELW +: SELW]) < DEPTH)) ?
          w_stage[s*SELW +: SELW] + SELW'(1) : SELW'(FWD_RF);
      end
      r_st_fwd <= w_st_ok;
      r_st_sel <= w_st_ok ? w_st_stage + SELW'(1) : SELW'(FWD_RF);
    end
  end

  assign ex_fwd_sel_o     = r_ex_sel;
  assign mem_st_fwd_o     = r_st_fwd;
  assign mem_st_fwd_sel_o = r_st_sel;

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fwd_hazard_ctrl : directed + random stimulus against an in-flight list model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_fwd_hazard_ctrl;

  localparam int NUM_SRC    = 2;
  localparam int RW         = 5;
  localparam int DEPTH      = 2;
  localparam int LOAD_STAGE = 2;
  localparam int STORE_SRC  = 1;
  localparam int SELW       = $clog2(DEPTH + 1);

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    id_valid_i = 1'b0;
  logic [NUM_SRC*RW-1:0]   id_rs_i = '0;
  logic [NUM_SRC-1:0]      id_rs_used_i = '0;
  logic [RW-1:0]           id_rd_i = '0;
  logic                    id_regwrite_i = 1'b0;
  logic                    id_load_i = 1'b0;
  logic                    id_store_i = 1'b0;
  logic                    hold_i = 1'b0;
  logic                    flush_i = 1'b0;
  logic                    stall_o;
  logic [NUM_SRC*SELW-1:0] ex_fwd_sel_o;
  logic                    mem_st_fwd_o;
  logic [SELW-1:0]         mem_st_fwd_sel_o;

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(
    .NUM_SRC    (NUM_SRC),
    .RW         (RW),
    .DEPTH      (DEPTH),
    .LOAD_STAGE (LOAD_STAGE),
    .STORE_SRC  (STORE_SRC),
    .SELW       (SELW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .id_valid_i       (id_valid_i),
    .id_rs_i          (id_rs_i),
    .id_rs_used_i     (id_rs_used_i),
    .id_rd_i          (id_rd_i),
    .id_regwrite_i    (id_regwrite_i),
    .id_load_i        (id_load_i),
    .id_store_i       (id_store_i),
    .hold_i           (hold_i),
    .flush_i          (flush_i),
    .stall_o          (stall_o),
    .ex_fwd_sel_o     (ex_fwd_sel_o),
    .mem_st_fwd_o     (mem_st_fwd_o),
    .mem_st_fwd_sel_o (mem_st_fwd_sel_o)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Model: list of instructions that have left ID, index 0 = most recent.
  typedef struct {
    bit v;
    int rd;
    bit wr;
    bit ld;
    bit st;
    int srs;
  } ins_t;

  ins_t pipe[DEPTH+1];
  int   exp_sel[NUM_SRC];
  bit   exp_stf;
  int   exp_sts;
  bit   last_stall;

  function automatic int find_prod(input int rs, input int from);
    for (int j = from; j <= DEPTH; j++)
      if (pipe[j].v && pipe[j].wr && pipe[j].rd == rs) return j;
    return -1;
  endfunction

  task automatic cycle(input bit r, input bit v, input int rs0, input int rs1,
                       input bit [1:0] used, input int rd, input bit rw,
                       input bit ld, input bit st, input bit h, input bit f);
    int rsv[NUM_SRC];
    bit m_stall;
    bit take;
    int j;
    int lim;
    rsv[0] = rs0;
    rsv[1] = rs1;
    @(negedge clk);
    rst           = r;
    hold_i        = h;
    flush_i       = f;
    id_valid_i    = v;
    id_rs_i       = {RW'(rs1), RW'(rs0)};
    id_rs_used_i  = used;
    id_rd_i       = RW'(rd);
    id_regwrite_i = rw;
    id_load_i     = ld;
    id_store_i    = st;
    #1;
    m_stall = 1'b0;
    if (!r && v && !f) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        if (used[s]) begin
          j = find_prod(rsv[s], 0);
          if (j >= 0 && pipe[j].ld) begin
            lim = (s == STORE_SRC && st) ? j + 2 : j + 1;
            if (lim < LOAD_STAGE) m_stall = 1'b1;
          end
        end
      end
    end
    check_val("stall", 32'(stall_o), 32'(m_stall));
    last_stall = stall_o;
    @(posedge clk);
    if (r) begin
      for (int k = 0; k <= DEPTH; k++) pipe[k].v = 1'b0;
      for (int s = 0; s < NUM_SRC; s++) exp_sel[s] = 0;
      exp_stf = 1'b0;
      exp_sts = 0;
    end else if (!h) begin
      take = v && !m_stall && !f;
      for (int s = 0; s < NUM_SRC; s++) begin
        j = find_prod(rsv[s], 0);
        exp_sel[s] = (take && used[s] && j >= 0 && (j + 1) <= DEPTH) ? j + 1 : 0;
      end
      exp_stf = 1'b0;
      exp_sts = 0;
      if (pipe[0].v && pipe[0].st && !f) begin
        j = find_prod(pipe[0].srs, 1);
        if (j >= 1 && pipe[j].ld && (j + 1) <= DEPTH) begin
          exp_stf = 1'b1;
          exp_sts = j + 1;
        end
      end
      for (int k = DEPTH; k >= 1; k--) pipe[k] = pipe[k-1];
      if (f) pipe[1].v = 1'b0;
      if (take) pipe[0] = '{v: 1'b1, rd: rd, wr: (rw && rd != 0), ld: ld, st: st, srs: rsv[STORE_SRC]};
      else      pipe[0].v = 1'b0;
    end
    #1;
    for (int s = 0; s < NUM_SRC; s++)
      check_val($sformatf("ex_sel%0d", s), 32'(ex_fwd_sel_o[s*SELW +: SELW]), 32'(exp_sel[s]));
    check_val("st_fwd", 32'(mem_st_fwd_o), 32'(exp_stf));
    check_val("st_sel", 32'(mem_st_fwd_sel_o), 32'(exp_sts));
  endtask

  task automatic ins(input int rs0, input int rs1, input bit [1:0] used, input int rd,
                     input bit rw, input bit ld, input bit st);
    cycle(1'b0, 1'b1, rs0, rs1, used, rd, rw, ld, st, 1'b0, 1'b0);
  endtask

  bit r_b, h_b, f_b, v_b, ld_b, st_b, rw_b;

  initial begin
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 3, 3, 3, 3, 1, 1, 0, 0, 0);
    check_val("rst_sel", 32'(ex_fwd_sel_o), 0);
    check_val("rst_stf", 32'(mem_st_fwd_o), 0);
    check_val("rst_stall", 32'(last_stall), 0);

    // ALU to ALU back to back
    ins(0, 0, 2'b00, 5, 1, 0, 0);
    ins(5, 5, 2'b11, 6, 1, 0, 0);
    check_val("alu_sel", 32'(ex_fwd_sel_o), 32'({2'd1, 2'd1}));
    check_val("alu_stall", 32'(last_stall), 0);

    // youngest producer wins, then further-back producers
    ins(0, 0, 2'b00, 7, 1, 0, 0);
    ins(0, 0, 2'b00, 7, 1, 0, 0);
    ins(7, 0, 2'b01, 10, 1, 0, 0);
    check_val("young_sel", 32'(ex_fwd_sel_o[SELW-1:0]), 1);
    ins(0, 0, 2'b00, 7, 1, 0, 0);
    ins(0, 0, 2'b00, 11, 1, 0, 0);
    ins(7, 0, 2'b01, 12, 1, 0, 0);
    check_val("back2_sel", 32'(ex_fwd_sel_o[SELW-1:0]), 2);
    ins(0, 0, 2'b00, 7, 1, 0, 0);
    ins(0, 0, 2'b00, 11, 1, 0, 0);
    ins(0, 0, 2'b00, 11, 1, 0, 0);
    ins(7, 0, 2'b01, 12, 1, 0, 0);
    check_val("back3_sel", 32'(ex_fwd_sel_o[SELW-1:0]), 0);

    // load-use: one stall with a bubble, then forward from stage 2
    ins(0, 0, 2'b00, 8, 1, 1, 0);
    ins(8, 1, 2'b11, 9, 1, 0, 0);
    check_val("lu_stall", 32'(last_stall), 1);
    check_val("lu_bubble", 32'(ex_fwd_sel_o[SELW-1:0]), 0);
    ins(8, 1, 2'b11, 9, 1, 0, 0);
    check_val("lu_stall2", 32'(last_stall), 0);
    check_val("lu_sel", 32'(ex_fwd_sel_o[SELW-1:0]), 2);

    // load then store of the loaded value
    ins(0, 0, 2'b00, 8, 1, 1, 0);
    ins(2, 8, 2'b11, 0, 0, 0, 1);
    check_val("ls_stall", 32'(last_stall), 0);
    ins(0, 0, 2'b00, 13, 1, 0, 0);
    check_val("ls_fwd", 32'(mem_st_fwd_o), 1);
    check_val("ls_sel", 32'(mem_st_fwd_sel_o), 2);

    // x0 producer and unused sources
    ins(0, 0, 2'b00, 0, 1, 0, 0);
    ins(0, 0, 2'b01, 14, 1, 0, 0);
    check_val("x0_sel", 32'(ex_fwd_sel_o), 0);
    ins(0, 0, 2'b00, 5, 1, 1, 0);
    ins(5, 5, 2'b00, 15, 1, 0, 0);
    check_val("unused_sel", 32'(ex_fwd_sel_o), 0);
    check_val("unused_stall", 32'(last_stall), 0);

    // hold freezes outputs for three cycles
    ins(0, 0, 2'b00, 5, 1, 0, 0);
    ins(5, 0, 2'b01, 16, 1, 0, 0);
    check_val("pre_hold_sel", 32'(ex_fwd_sel_o[SELW-1:0]), 1);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 16, 16, 2'b11, 17, 1, 0, 0, 1, 0);
      check_val("hold_sel", 32'(ex_fwd_sel_o[SELW-1:0]), 1);
    end
    ins(5, 0, 2'b01, 19, 1, 0, 0);
    check_val("resume_sel", 32'(ex_fwd_sel_o[SELW-1:0]), 2);

    // flush kills ID and ID/EX
    ins(0, 0, 2'b00, 5, 1, 0, 0);
    cycle(0, 1, 5, 0, 2'b01, 18, 1, 0, 0, 0, 1);
    check_val("flush_sel", 32'(ex_fwd_sel_o), 0);
    ins(5, 0, 2'b01, 20, 1, 0, 0);
    check_val("post_flush_sel", 32'(ex_fwd_sel_o[SELW-1:0]), 0);

    // reset mid-stream
    ins(0, 0, 2'b00, 5, 1, 0, 0);
    cycle(1, 1, 5, 5, 2'b11, 21, 1, 0, 0, 0, 0);
    check_val("mid_rst_sel", 32'(ex_fwd_sel_o), 0);
    ins(5, 5, 2'b11, 22, 1, 0, 0);
    check_val("post_rst_sel", 32'(ex_fwd_sel_o), 0);

    for (int i = 0; i < 3000; i++) begin
      r_b  = ($urandom_range(99) < 2);
      h_b  = ($urandom_range(99) < 10);
      f_b  = ($urandom_range(99) < 8);
      v_b  = ($urandom_range(99) < 85);
      ld_b = ($urandom_range(99) < 30);
      st_b = !ld_b && ($urandom_range(99) < 25);
      rw_b = ld_b || (!st_b && ($urandom_range(99) < 80));
      cycle(r_b, v_b, int'($urandom_range(3)), int'($urandom_range(3)),
            2'($urandom_range(3)), int'($urandom_range(3)), rw_b, ld_b, st_b, h_b, f_b);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
